lockpick_result_sink: RTL
=========================

Name: lockpick_result_sink

Overview:
- Downstream consumer of the lockpick game's serial result stream (`output_valid`/`output_data`/`status`).
- Captures each 32-byte result frame into a local buffer and checks every byte against the pattern implied by `status`.
- Reports per-frame verdicts and keeps saturating win/error/lockout/bad-frame counters for board-level readout and bring-up checks.

Parameters:
- FRAME_BYTES, 32, bytes per result frame; power of two, ≥4.
- CNT_W, 8, width of each event counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, result byte strobe (the game's output_valid).
- in_data, input, 8, result byte (the game's output_data).
- in_status, input, 2, game status: 01 error, 10 win, 11 locked out, 00 none.
- clr_counts, input, 1, synchronous clear of all counters.
- rd_addr, input, log2(FRAME_BYTES), buffer read index.
- rd_data, output, 8, buffered byte at rd_addr, registered.
- frame_done, output, 1, one-cycle pulse when a frame closes.
- frame_ok, output, 1, last frame complete and all bytes matched; held until next frame_done.
- frame_code, output, 2, in_status latched at byte 0 of last frame; held.
- frame_trunc, output, 1, last frame ended early or overran; held.
- win_count / err_count / lock_count / bad_count, output, CNT_W each, saturating event counters.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset state: all outputs 0, FSM in IDLE, byte index 0, mismatch flag 0. Buffer contents are not reset.
- FSM states: IDLE, CAPTURE, CLOSE, DRAIN.
- IDLE, on in_valid=1: write in_data to buf[0], latch code=in_status, idx←1. Set mismatch if in_data≠expected(code,0) or code=00. Go to CAPTURE.
- CAPTURE, in_valid=1: write buf[idx], OR the byte mismatch into the flag, and set the flag if in_status≠code. idx increments. On the byte where idx=FRAME_BYTES-1, go to CLOSE.
- CAPTURE, in_valid=0: truncated frame. Set trunc=1 and go to CLOSE.
- Expected byte at index i:
  - code 10: CE for even i, FA for odd i.
  - code 11: AD for even i, DE for odd i.
  - code 01: D0 for even i, BA for odd i.
  - code 00: always mismatch.
- CLOSE (exactly one cycle):
  - frame_done=1.
  - frame_ok ← !mismatch && !trunc.
  - frame_code ← code; frame_trunc ← trunc.
  - Counters: if frame_ok, increment win/err/lock per code 10/01/11; otherwise increment bad_count.
  - Next state: if in_valid=1 during CLOSE, it is an overrun. Set frame_trunc=1 on the next cycle, force frame_ok=0, undo the good-count increment and increment bad_count instead. Then go to DRAIN. If in_valid=0, go to IDLE.
- DRAIN: ignore data; go to IDLE when in_valid=0.
- Verdict latency: frame_done is asserted the cycle after the last captured byte. frame_ok, frame_code and frame_trunc are valid in the same cycle as frame_done, and stay stable until the next frame_done.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_counts zeroes all counters the next cycle. When it coincides with a CLOSE increment, the clear wins. Verdict outputs are unaffected.
- rd_data ← buf[rd_addr] each cycle (1-cycle latency). A read of an address written in the same cycle returns the old value.
- rst_n asserted mid-frame: the partial frame is discarded, no counter changes, FSM returns to IDLE immediately.
- Minimum gap between frames: one in_valid=0 cycle after CLOSE, or after DRAIN exits.

Test Plan:
- Win frame: status=10, 32 bytes CE,FA,CE,FA… -> frame_done 1 cycle after byte 31; frame_ok=1; frame_code=10; win_count=1; rd_addr=5 gives rd_data=FA.
- Error then lockout frames: status=01 with D0/BA, then status=11 with AD/DE -> err_count=1, lock_count=1, both frame_ok=1.
- Corrupt byte: status=10 frame with byte 17=00 -> frame_ok=0, frame_trunc=0, bad_count=1, win_count unchanged.
- Truncation/overrun:
  - in_valid drops after 20 bytes -> frame_trunc=1, bad_count+1.
  - Valid frame of 40 consecutive bytes -> frame_trunc=1, bad_count+1, win_count unchanged, FSM waits in DRAIN until in_valid=0.
- Saturation/clear: 260 good win frames with CNT_W=8 -> win_count=255. Pulse clr_counts on a CLOSE cycle -> all counters 0.
- Reset mid-frame: assert rst_n=0 at byte 10 -> all outputs 0. A following full valid frame is then counted correctly.

Source files
------------

// File: rtl/lockpick_result_sink.sv
// Lockpick result sink: captures the game's serial result frames, checks each
// byte against the pattern implied by the frame status, and keeps verdicts and
// saturating event counters for board-level readout.
module lockpick_result_sink #(
  parameter int unsigned FRAME_BYTES = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  input  logic [1:0]                     in_status,
  input  logic                           clr_counts,
  input  logic [$clog2(FRAME_BYTES)-1:0] rd_addr,
  output logic [7:0]                     rd_data,
  output logic                           frame_done,
  output logic                           frame_ok,
  output logic [1:0]                     frame_code,
  output logic                           frame_trunc,
  output logic [CNT_W-1:0]               win_count,
  output logic [CNT_W-1:0]               err_count,
  output logic [CNT_W-1:0]               lock_count,
  output logic [CNT_W-1:0]               bad_count
);

  localparam int unsigned      IDX_W     = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [1:0]       CODE_NONE = 2'b00;
  localparam logic [1:0]       CODE_ERR  = 2'b01;
  localparam logic [1:0]       CODE_WIN  = 2'b10;
  localparam logic [1:0]       CODE_LOCK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CLOSE   = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  state_e             state_q;
  logic [1:0]         code_q;
  logic [IDX_W-1:0]   idx_q;
  logic               mismatch_q;
  logic [7:0]         buf_q [FRAME_BYTES];

  logic [7:0]         rd_data_q;
  logic               frame_done_q;
  logic               frame_ok_q;
  logic [1:0]         frame_code_q;
  logic               frame_trunc_q;
  logic [CNT_W-1:0]   win_q;
  logic [CNT_W-1:0]   err_q;
  logic [CNT_W-1:0]   lock_q;
  logic [CNT_W-1:0]   bad_q;

  logic               wr_en_c;
  logic [IDX_W-1:0]   wr_addr_c;
  logic [1:0]         byte_code_c;
  logic               byte_mis_c;
  logic               mis_acc_c;

  // Pattern byte for a given status code and index parity
  function automatic logic [7:0] expected_byte(input logic [1:0] code, input logic odd);
    logic [7:0] val;
    case (code)
      CODE_WIN:  val = odd ? 8'hFA : 8'hCE;
      CODE_LOCK: val = odd ? 8'hDE : 8'hAD;
      CODE_ERR:  val = odd ? 8'hBA : 8'hD0;
      default:   val = 8'h00;
    endcase
    return val;
  endfunction

  // Counter increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Write address/enable and per-byte mismatch for the incoming byte
  always_comb begin
    wr_en_c     = 1'b0;
    wr_addr_c   = idx_q;
    byte_code_c = code_q;
    if (state_q == ST_IDLE) begin
      wr_addr_c   = '0;
      byte_code_c = in_status;
    end
    if (in_valid && (state_q == ST_IDLE || state_q == ST_CAPTURE)) begin
      wr_en_c = 1'b1;
    end
    // In IDLE the code is taken from in_status, so the status term is inert there
    byte_mis_c = (in_data != expected_byte(byte_code_c, wr_addr_c[0]))
               || (byte_code_c == CODE_NONE)
               || (in_status != byte_code_c);
    mis_acc_c  = mismatch_q | byte_mis_c;
  end

  // Frame buffer storage (not reset)
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      buf_q[wr_addr_c] <= in_data;
    end
  end

  // Frame FSM, verdict outputs and registered buffer read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      code_q        <= 2'b00;
      idx_q         <= '0;
      mismatch_q    <= 1'b0;
      rd_data_q     <= 8'h00;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_code_q  <= 2'b00;
      frame_trunc_q <= 1'b0;
    end else begin
      rd_data_q    <= buf_q[rd_addr];
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            code_q     <= in_status;
            idx_q      <= IDX_W'(1);
            mismatch_q <= byte_mis_c;
            state_q    <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (in_valid) begin
            mismatch_q <= mis_acc_c;
            idx_q      <= idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              // Verdict lands together with frame_done in the CLOSE cycle
              state_q       <= ST_CLOSE;
              frame_done_q  <= 1'b1;
              frame_ok_q    <= !mis_acc_c;
              frame_code_q  <= code_q;
              frame_trunc_q <= 1'b0;
            end
          end else begin
            state_q       <= ST_CLOSE;
            frame_done_q  <= 1'b1;
            frame_ok_q    <= 1'b0;
            frame_code_q  <= code_q;
            frame_trunc_q <= 1'b1;
          end
        end
        ST_CLOSE: begin
          if (in_valid) begin
            // Byte beyond the frame end: demote the verdict to an overrun
            frame_ok_q    <= 1'b0;
            frame_trunc_q <= 1'b1;
            state_q       <= ST_DRAIN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!in_valid) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Event counters: settled as CLOSE ends so an overrun counts only as bad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      err_q  <= '0;
      lock_q <= '0;
      bad_q  <= '0;
    end else if (clr_counts) begin
      win_q  <= '0;
      err_q  <= '0;
      lock_q <= '0;
      bad_q  <= '0;
    end else if (state_q == ST_CLOSE) begin
      if (frame_ok_q && !in_valid) begin
        case (code_q)
          CODE_WIN:  win_q  <= sat_inc(win_q);
          CODE_ERR:  err_q  <= sat_inc(err_q);
          CODE_LOCK: lock_q <= sat_inc(lock_q);
          default:   bad_q  <= sat_inc(bad_q);
        endcase
      end else begin
        bad_q <= sat_inc(bad_q);
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign frame_code  = frame_code_q;
  assign frame_trunc = frame_trunc_q;
  assign win_count   = win_q;
  assign err_count   = err_q;
  assign lock_count  = lock_q;
  assign bad_count   = bad_q;

endmodule
